// File: rtl/midi_parser_if.sv
// Received-byte bus from the UART receiver into the MIDI parser.
// The source drives rx_data and rx_valid together.
// rx_valid is a one-cycle strobe per byte.
// There is no ready: the parser accepts a byte on every cycle, so rx_valid may stay high on consecutive cycles.
interface midi_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (
        output rx_data,
        output rx_valid
    );

    modport slave (
        input rx_data,
        input rx_valid
    );
endinterface

// File: rtl/midi_parser.sv
// Monophonic, channel-filtered MIDI byte parser with running status.
// It holds the voice control registers that feed the exponentiator:
// note, velocity, gate, pitch bend, and coarse/fine tune.
// Every output is registered and changes on the edge that captures the completing data byte.
module midi_parser #(
    parameter logic [3:0] CHANNEL   = 4'd0,
    parameter logic [6:0] CC_COARSE = 7'd20,
    parameter logic [6:0] CC_FINE   = 7'd21
) (
    input  logic           clk_midi,
    input  logic           rst_midi,
    midi_parser_if.slave   rx,
    output logic [6:0]     note,
    output logic [6:0]     velocity,
    output logic           gate,
    output logic           note_stb,
    output logic [13:0]    pitch,
    output logic [6:0]     coarse_tune,
    output logic [6:0]     fine_tune,
    output logic [1:0]     dbg_state
);

    // IDLE means there is no running status.
    // D1 waits for the first data byte.
    // D2 waits for the second data byte.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        D1   = 2'd1,
        D2   = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  msg_type;
    logic [3:0]  next_type;
    logic        match;
    logic        next_match;
    logic [6:0]  d1;
    logic [6:0]  next_d1;
    logic        exec;

    logic        is_realtime;
    logic        is_common;
    logic        is_status;
    logic        is_data;
    logic        two_byte;
    logic [6:0]  d2;

    assign dbg_state = state;

    // Byte classification.
    // Realtime bytes are F8..FF, system common bytes are F0..F7, and any other byte with bit 7 set is channel status.
    assign is_realtime = rx.rx_valid && (rx.rx_data[7:3] == 5'b11111);
    assign is_common   = rx.rx_valid && (rx.rx_data[7:3] == 5'b11110);
    assign is_status   = rx.rx_valid && rx.rx_data[7] && (rx.rx_data[7:4] != 4'hF);
    assign is_data     = rx.rx_valid && !rx.rx_data[7];
    assign d2          = rx.rx_data[6:0];

    // Program change (Cx) and channel pressure (Dx) carry one data byte.
    // Every other channel message carries two.
    assign two_byte = (msg_type != 4'hC) && (msg_type != 4'hD);

    // Parser state and running-status registers.
    always_ff @(posedge clk_midi or negedge rst_midi) begin
        if (!rst_midi) begin
            state    <= IDLE;
            msg_type <= 4'h0;
            match    <= 1'b0;
            d1       <= 7'd0;
        end else begin
            state    <= next_state;
            msg_type <= next_type;
            match    <= next_match;
            d1       <= next_d1;
        end
    end

    // Next-state decode.
    // Realtime bytes fall through every branch, so the state, the running status and d1 are all left untouched.
    always_comb begin
        next_state = state;
        next_type  = msg_type;
        next_match = match;
        next_d1    = d1;
        exec       = 1'b0;

        if (is_common) begin
            next_state = IDLE;
        end else if (is_status) begin
            // A new status byte abandons any partial message.
            next_state = D1;
            next_type  = rx.rx_data[7:4];
            next_match = (rx.rx_data[3:0] == CHANNEL);
        end else if (is_data) begin
            case (state)
                IDLE: begin
                    next_state = IDLE;
                end
                D1: begin
                    next_d1 = rx.rx_data[6:0];
                    // A one-byte message completes here and is ignored.
                    // Stay in D1 so running status continues.
                    next_state = two_byte ? D2 : D1;
                end
                D2: begin
                    exec       = 1'b1;
                    next_state = D1;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // Message execution.
    // This only happens on a completed two-byte message for our channel.
    // note_stb is cleared every cycle unless a note-on fires.
    always_ff @(posedge clk_midi or negedge rst_midi) begin
        if (!rst_midi) begin
            note        <= 7'd0;
            velocity    <= 7'd0;
            gate        <= 1'b0;
            note_stb    <= 1'b0;
            pitch       <= 14'h2000;
            coarse_tune <= 7'd0;
            fine_tune   <= 7'd0;
        end else begin
            note_stb <= 1'b0;
            if (exec && match) begin
                case (msg_type)
                    4'h9: begin
                        if (d2 != 7'd0) begin
                            note     <= d1;
                            velocity <= d2;
                            gate     <= 1'b1;
                            note_stb <= 1'b1;
                        end else if (d1 == note) begin
                            // A note-on with velocity 0 acts as a note-off.
                            gate <= 1'b0;
                        end
                    end
                    4'h8: begin
                        // Only releasing the held note closes the gate.
                        if (d1 == note) begin
                            gate <= 1'b0;
                        end
                    end
                    4'hB: begin
                        // These are independent checks, so equal controller numbers write both registers.
                        if (d1 == CC_COARSE) begin
                            coarse_tune <= d2;
                        end
                        if (d1 == CC_FINE) begin
                            fine_tune <= d2;
                        end
                    end
                    4'hE: begin
                        pitch <= {d2, d1};
                    end
                    default: begin
                        // Aftertouch (Ax) is ignored.
                        // Cx and Dx never reach D2, so they never execute.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_midi_parser.sv
// Directed testbench for midi_parser with CHANNEL=0, CC_COARSE=20 and CC_FINE=21.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
module tb_midi_parser;

    logic        clk_midi;
    logic        rst_midi;
    logic [6:0]  note;
    logic [6:0]  velocity;
    logic        gate;
    logic        note_stb;
    logic [13:0] pitch;
    logic [6:0]  coarse_tune;
    logic [6:0]  fine_tune;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    midi_parser_if rx ();

    midi_parser dut (
        .clk_midi    (clk_midi),
        .rst_midi    (rst_midi),
        .rx          (rx.slave),
        .note        (note),
        .velocity    (velocity),
        .gate        (gate),
        .note_stb    (note_stb),
        .pitch       (pitch),
        .coarse_tune (coarse_tune),
        .fine_tune   (fine_tune),
        .dbg_state   (dbg_state)
    );

    // Clock and reset.
    initial clk_midi = 1'b0;
    always #5 clk_midi = ~clk_midi;

    // Driver tasks.
    // Each byte is held for exactly one cycle, so consecutive calls give back-to-back bytes.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_midi);
        rx.rx_data  = b;
        rx.rx_valid = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk_midi);
        rx.rx_valid = 1'b0;
        rx.rx_data  = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk_midi);
        rst_midi = 1'b0;
        rx.rx_valid = 1'b0;
        @(negedge clk_midi);
        @(negedge clk_midi);
        rst_midi = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk_midi);
        total++; if (note !== 7'd0) begin bad++; $display("FAIL reset.note got=%0d exp=0", note); end
        total++; if (velocity !== 7'd0) begin bad++; $display("FAIL reset.velocity got=%0d exp=0", velocity); end
        total++; if (gate !== 1'b0 || note_stb !== 1'b0) begin bad++; $display("FAIL reset.gate_stb got=%b%b exp=00", gate, note_stb); end
        total++; if (pitch !== 14'h2000) begin bad++; $display("FAIL reset.pitch got=%h exp=2000", pitch); end
        total++; if (coarse_tune !== 7'd0 || fine_tune !== 7'd0) begin bad++; $display("FAIL reset.tune got=%0d/%0d exp=0/0", coarse_tune, fine_tune); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset.state got=%0d exp=0", dbg_state); end
    endtask

    task automatic test_note_on();
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64); idle();
        total++; if (note !== 7'd60) begin bad++; $display("FAIL note_on.note got=%0d exp=60", note); end
        total++; if (velocity !== 7'd100) begin bad++; $display("FAIL note_on.velocity got=%0d exp=100", velocity); end
        total++; if (gate !== 1'b1) begin bad++; $display("FAIL note_on.gate got=%b exp=1", gate); end
        total++; if (note_stb !== 1'b1) begin bad++; $display("FAIL note_on.stb got=%b exp=1", note_stb); end
        total++; if (pitch !== 14'h2000) begin bad++; $display("FAIL note_on.pitch got=%h exp=2000", pitch); end
        idle();
        total++; if (note_stb !== 1'b0) begin bad++; $display("FAIL note_on.stb_width got=%b exp=0", note_stb); end
        total++; if (dbg_state !== 2'd1) begin bad++; $display("FAIL note_on.state got=%0d exp=1", dbg_state); end
    endtask

    task automatic test_running_status();
        send_byte(8'h3E); send_byte(8'h50); idle();
        total++; if (note !== 7'd62 || velocity !== 7'd80) begin bad++; $display("FAIL running.note got=%0d/%0d exp=62/80", note, velocity); end
        total++; if (note_stb !== 1'b1) begin bad++; $display("FAIL running.stb got=%b exp=1", note_stb); end
        send_byte(8'h3C); send_byte(8'h00); idle();
        total++; if (gate !== 1'b1 || note !== 7'd62) begin bad++; $display("FAIL running.mismatch_off got=%b/%0d exp=1/62", gate, note); end
        send_byte(8'h80); send_byte(8'h3E); send_byte(8'h40); idle();
        total++; if (gate !== 1'b0 || note !== 7'd62) begin bad++; $display("FAIL running.note_off got=%b/%0d exp=0/62", gate, note); end
    endtask

    task automatic test_pitch();
        send_byte(8'hE0); send_byte(8'h00); send_byte(8'hF8); send_byte(8'h7F); idle();
        total++; if (pitch !== 14'h3F80) begin bad++; $display("FAIL pitch.realtime got=%h exp=3f80", pitch); end
        send_byte(8'hE0); send_byte(8'h7F); send_byte(8'h7F); idle();
        total++; if (pitch !== 14'h3FFF) begin bad++; $display("FAIL pitch.max got=%h exp=3fff", pitch); end
        send_byte(8'hE0); send_byte(8'h00); send_byte(8'h40); idle();
        total++; if (pitch !== 14'h2000) begin bad++; $display("FAIL pitch.centre got=%h exp=2000", pitch); end
    endtask

    task automatic test_cc();
        send_byte(8'hB0); send_byte(8'h14); send_byte(8'h05);
        send_byte(8'hB0); send_byte(8'h15); send_byte(8'h7F);
        send_byte(8'hB0); send_byte(8'h07); send_byte(8'h33); idle();
        total++; if (coarse_tune !== 7'd5) begin bad++; $display("FAIL cc.coarse got=%0d exp=5", coarse_tune); end
        total++; if (fine_tune !== 7'd127) begin bad++; $display("FAIL cc.fine got=%0d exp=127", fine_tune); end
        total++; if (note !== 7'd62 || gate !== 1'b0 || pitch !== 14'h2000) begin bad++; $display("FAIL cc.others got=%0d/%b/%h exp=62/0/2000", note, gate, pitch); end
    endtask

    task automatic test_channel();
        send_byte(8'h91); send_byte(8'h40); send_byte(8'h40); idle();
        total++; if (note_stb !== 1'b0) begin bad++; $display("FAIL channel.stb got=%b exp=0", note_stb); end
        total++; if (note !== 7'd62 || velocity !== 7'd80 || gate !== 1'b0) begin bad++; $display("FAIL channel.voice got=%0d/%0d/%b exp=62/80/0", note, velocity, gate); end
    endtask

    task automatic test_sysex();
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF0); send_byte(8'h45); send_byte(8'h40); idle();
        total++; if (note !== 7'd62 || gate !== 1'b0) begin bad++; $display("FAIL sysex.note got=%0d/%b exp=62/0", note, gate); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL sysex.state got=%0d exp=0", dbg_state); end
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'hB0); send_byte(8'h14); send_byte(8'h09); idle();
        total++; if (coarse_tune !== 7'd9) begin bad++; $display("FAIL abandon.coarse got=%0d exp=9", coarse_tune); end
        total++; if (note !== 7'd62 || gate !== 1'b0) begin bad++; $display("FAIL abandon.note got=%0d/%b exp=62/0", note, gate); end
    endtask

    task automatic test_back_to_back();
        send_byte(8'h90); send_byte(8'h30); send_byte(8'h10); send_byte(8'h31);
        total++; if (note !== 7'h30 || note_stb !== 1'b1) begin bad++; $display("FAIL b2b.first got=%0d/%b exp=48/1", note, note_stb); end
        send_byte(8'h20);
        total++; if (note_stb !== 1'b0) begin bad++; $display("FAIL b2b.gap_stb got=%b exp=0", note_stb); end
        idle();
        total++; if (note !== 7'h31 || velocity !== 7'h20 || gate !== 1'b1 || note_stb !== 1'b1) begin bad++; $display("FAIL b2b.second got=%0d/%0d/%b/%b exp=49/32/1/1", note, velocity, gate, note_stb); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_byte(8'h90); idle();
        rst_midi = 1'b0;
        @(negedge clk_midi);
        rst_midi = 1'b1;
        send_byte(8'h3C); send_byte(8'h64); idle();
        total++; if (note !== 7'd0 || velocity !== 7'd0 || gate !== 1'b0 || note_stb !== 1'b0) begin bad++; $display("FAIL reset_mid.voice got=%0d/%0d/%b/%b exp=0/0/0/0", note, velocity, gate, note_stb); end
        total++; if (pitch !== 14'h2000 || coarse_tune !== 7'd0 || fine_tune !== 7'd0) begin bad++; $display("FAIL reset_mid.ctrl got=%h/%0d/%0d exp=2000/0/0", pitch, coarse_tune, fine_tune); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_mid.state got=%0d exp=0", dbg_state); end
    endtask

    // Sequence and final report.
    initial begin
        rst_midi    = 1'b0;
        rx.rx_valid = 1'b0;
        rx.rx_data  = 8'h00;
        test_reset();
        test_note_on();
        test_running_status();
        test_pitch();
        test_cc();
        test_channel();
        test_sysex();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/midi_parser.md
# midi_parser

Byte-level MIDI message parser that sits directly upstream of the exponentiator. It consumes received MIDI bytes from the UART receiver and holds the voice control registers (note, pitch bend, coarse/fine tune) that drive the exponentiator's tuning-word lookup. It is monophonic and channel-filtered, supports running status, and updates registered outputs one cycle after the completing data byte.

## Interface
- `CHANNEL`, default 4'd0: MIDI channel accepted, 0–15.
- `CC_COARSE`, default 7'd20: controller number written to `coarse_tune`.
- `CC_FINE`, default 7'd21: controller number written to `fine_tune`.

- `clk_midi`, input, 1: system clock; all logic is on the rising edge.
- `rst_midi`, input, 1: asynchronous, active-low reset.
- `rx_data`, input, 8: received MIDI byte; valid only when `rx_valid` is high.
- `rx_valid`, input, 1: one-cycle strobe per byte; may be high on consecutive cycles.
- `note`, output, 7: current note number.
- `velocity`, output, 7: velocity of the last accepted note-on.
- `gate`, output, 1: high while a note is held.
- `note_stb`, output, 1: one-cycle pulse on every accepted note-on.
- `pitch`, output, 14: pitch bend value; 14'h2000 is centre.
- `coarse_tune`, output, 7: last value received on `CC_COARSE`.
- `fine_tune`, output, 7: last value received on `CC_FINE`.

## Operation
- Byte classes:
  - Realtime (8'hF8–8'hFF): ignored entirely. FSM state, running status and the stored first data byte are unchanged.
  - System common (8'hF0–8'hF7): running status is cleared; FSM goes to IDLE.
  - Channel status (8'h80–8'hEF): latches the type (upper nibble) and sets the match flag = (lower nibble == `CHANNEL`).
  - Data (bit 7 = 0).
- Data length per type: 8x/9x/Ax/Bx/Ex take 2 data bytes; Cx/Dx take 1.
- FSM states:
  - IDLE: no running status. Data bytes are discarded. A channel status byte goes to D1.
  - D1: on a data byte, store it as d1. For 2-byte types go to D2. For 1-byte types the message is complete (ignored); stay in D1.
  - D2: on a data byte, the message is complete; execute it and return to D1 (running status).
  - A channel status byte in any state abandons the partial message and goes to D1 with the new type.
- Message execution (only when the match flag is set; otherwise the message is consumed and discarded):
  - 9x with d2 ≠ 0: `note` = d1, `velocity` = d2, `gate` = 1, `note_stb` = 1.
  - 9x with d2 = 0, or 8x: if d1 == `note`, then `gate` = 0. Otherwise there is no change.
  - Bx: d1 == `CC_COARSE` sets `coarse_tune` = d2; d1 == `CC_FINE` sets `fine_tune` = d2; other controllers are ignored.
  - Ex: `pitch` = {d2, d1} (d1 is the LSB 7 bits).
  - Ax, Cx, Dx: ignored.
- If `CC_COARSE` == `CC_FINE`, both registers are written.

## Timing
- Reset (asynchronous, `rst_midi` low):
  - FSM = IDLE, running status cleared.
  - `note` = 0, `velocity` = 0, `gate` = 0, `note_stb` = 0.
  - `pitch` = 14'h2000, `coarse_tune` = 0, `fine_tune` = 0.
- Latency: an output changes on the first rising edge after the cycle in which the completing byte has `rx_valid` high.
- `note_stb` is high for exactly one cycle.
- Back-to-back bytes on consecutive cycles are fully supported, with no bubbles required.
- A realtime byte between two data bytes of one message does not break the message.
- Reset asserted mid-message discards the partial message. After release, data bytes are ignored until a status byte arrives.
- Outputs hold their values indefinitely between messages.

## Test plan
- Reset release, then 90 3C 64 → one cycle later `note`=60, `velocity`=100, `gate`=1, `note_stb` high for 1 cycle; `pitch`=2000h.
- 90 3C 64, then running-status bytes 3E 50, 3C 00 → `note`=62 after 3E 50. 3C 00 leaves `gate`=1 (note mismatch). A following 80 3E 40 → `gate`=0.
- E0 00 7F with an F8 inserted between the data bytes → `pitch`=3F80h. Then E0 7F 7F → 3FFFh. Then E0 00 40 → 2000h.
- B0 14 05, B0 15 7F, B0 07 33 → `coarse_tune`=5, `fine_tune`=127, nothing else changes. With CHANNEL=0, 91 40 40 → no output change.
- 90 3C, then F0 (sysex start), then 45 40 → no note update. Also 90 3C, then B0 14 09 → `coarse_tune`=9 and the note is abandoned.
- Assert `rst_midi` between 90 and 3C, release, then send 3C 64 → all outputs stay at reset values.
